// File: rtl/violet_pattern_sequencer_if.sv
// Button/LED exchange with the Violet panel, plus pattern status outputs.
// The master drives buttons; the slave (sequencer) drives everything else.
interface violet_pattern_sequencer_if;
   logic [15:0] buttons;
   logic [15:0] leds;
   logic [1:0]  mode;
   logic        paused;
   logic        fast;
   logic        step_tick;

   modport master (
      output buttons,
      input  leds, mode, paused, fast, step_tick
   );

   modport slave (
      input  buttons,
      output leds, mode, paused, fast, step_tick
   );
endinterface

// File: rtl/violet_pattern_sequencer.sv
// Selectable, pausable, speed-switchable LED pattern engine for the Violet panel.
// Buttons 3:0 are debounced by hold counters; all outputs come straight from registers.
module violet_pattern_sequencer #(
   parameter int CLK_FREQ    = 25000000,
   parameter int STEP_HZ     = 10,
   parameter int HOLD_CYCLES = 2500
)(
   input  logic                          i_clk,
   input  logic                          nrst,
   violet_pattern_sequencer_if.slave     bus
);
   localparam int DIV      = CLK_FREQ / STEP_HZ;
   localparam int DIV_FAST = DIV / 4;
   localparam int CW       = $clog2(DIV);
   localparam int HW       = $clog2(HOLD_CYCLES + 1);

   typedef enum logic [1:0] {M_CHASE, M_BOUNCE, M_FILL, M_BLINK} mode_t;

   logic [3:0]    r_btn;
   logic [3:0]    w_evt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_next;
   logic [CW-1:0] w_lim_m1;
   mode_t         r_mode;
   mode_t         w_mode_next;
   logic [15:0]   r_leds;
   logic [15:0]   w_leds_next;
   logic [3:0]    r_pos;
   logic [3:0]    w_pos_next;
   logic          r_up;
   logic          w_up_next;
   logic          r_drain;
   logic          w_drain_next;
   logic          r_paused;
   logic          r_fast;
   logic          r_step_tick;
   logic          w_mode_evt;
   logic          w_pause_evt;
   logic          w_single_evt;
   logic          w_fast_evt;
   logic          w_div_tick;
   logic          w_step;
   logic          w_unused_bits;

   assign w_unused_bits = ^{bus.buttons[15], bus.buttons[13:4]};

   // One event per high period: fires only on the transition into saturation.
   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_press
      logic [HW-1:0] r_hold;

      always_ff @(posedge i_clk or negedge nrst) begin
         if (!nrst) begin
            r_hold <= '0;
         end else if (!r_btn[gi]) begin
            r_hold <= '0;
         end else if (r_hold != HW'(HOLD_CYCLES)) begin
            r_hold <= r_hold + 1'b1;
         end
      end

      assign w_evt[gi] = r_btn[gi] && (r_hold == HW'(HOLD_CYCLES - 1));
   end

   assign w_mode_evt   = w_evt[0];
   assign w_pause_evt  = w_evt[1];
   assign w_single_evt = w_evt[2];
   assign w_fast_evt   = w_evt[3];

   assign w_lim_m1   = r_fast ? CW'(DIV_FAST - 1) : CW'(DIV - 1);
   assign w_div_tick = !r_paused && (r_cnt == w_lim_m1);
   // A mode change always wins; a pause toggle swallows a coincident divider tick.
   assign w_step     = !w_mode_evt &&
                       ((w_div_tick && !w_pause_evt) || (w_single_evt && r_paused));

   always_comb begin
      w_cnt_next = r_cnt;
      if (w_mode_evt || w_fast_evt) begin
         w_cnt_next = '0;
      end else if (!r_paused) begin
         w_cnt_next = (r_cnt == w_lim_m1) ? '0 : r_cnt + 1'b1;
      end
   end

   always_comb begin
      w_mode_next  = r_mode;
      w_leds_next  = r_leds;
      w_pos_next   = r_pos;
      w_up_next    = r_up;
      w_drain_next = r_drain;
      if (w_mode_evt) begin
         w_mode_next  = mode_t'(r_mode + 2'd1);
         w_pos_next   = 4'd0;
         w_up_next    = 1'b1;
         w_drain_next = 1'b0;
         case (w_mode_next)
            M_FILL:  w_leds_next = 16'h0000;
            M_BLINK: w_leds_next = 16'h00FF;
            default: w_leds_next = 16'h0001;
         endcase
      end else if (w_step) begin
         case (r_mode)
            M_CHASE: begin
               w_leds_next = bus.buttons[14] ? {r_leds[0], r_leds[15:1]}
                                             : {r_leds[14:0], r_leds[15]};
            end
            M_BOUNCE: begin
               if (r_up) begin
                  w_pos_next = r_pos + 4'd1;
                  if (r_pos == 4'd14) w_up_next = 1'b0;
               end else begin
                  w_pos_next = r_pos - 4'd1;
                  if (r_pos == 4'd1) w_up_next = 1'b1;
               end
               w_leds_next = 16'h0001 << w_pos_next;
            end
            M_FILL: begin
               w_leds_next = {r_leds[14:0], ~r_drain};
               if (!r_drain && (w_leds_next == 16'hFFFF)) w_drain_next = 1'b1;
               if (r_drain && (w_leds_next == 16'h0000))  w_drain_next = 1'b0;
            end
            default: w_leds_next = ~r_leds;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge nrst) begin
      if (!nrst) begin
         r_btn       <= '0;
         r_cnt       <= '0;
         r_mode      <= M_CHASE;
         r_leds      <= 16'h0001;
         r_pos       <= 4'd0;
         r_up        <= 1'b1;
         r_drain     <= 1'b0;
         r_paused    <= 1'b0;
         r_fast      <= 1'b0;
         r_step_tick <= 1'b0;
      end else begin
         r_btn       <= bus.buttons[3:0];
         r_cnt       <= w_cnt_next;
         r_mode      <= w_mode_next;
         r_leds      <= w_leds_next;
         r_pos       <= w_pos_next;
         r_up        <= w_up_next;
         r_drain     <= w_drain_next;
         r_paused    <= r_paused ^ w_pause_evt;
         r_fast      <= r_fast ^ w_fast_evt;
         r_step_tick <= w_step;
      end
   end

   // step_tick rises on the same edge that loads the updated pattern.
   assign bus.leds      = r_leds;
   assign bus.mode      = r_mode;
   assign bus.paused    = r_paused;
   assign bus.fast      = r_fast;
   assign bus.step_tick = r_step_tick;
endmodule
